// File: rtl/cpu_output_fifo.sv
// Show-ahead byte FIFO behind the CPU output port.
// It applies back-pressure through full/stall and keeps a sticky flag for dropped writes.
module cpu_output_fifo #(
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    input  logic              rd_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              stall,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;

    // Flags depend only on the registered level, so they never loop back through the handshake.
    assign rd_valid = (level != '0);
    assign empty    = (level == '0);
    assign full     = (level == FULL_LEVEL);
    assign stall    = full;

    assign pop  = rd_valid & rd_ready;
    assign push = wr_en & (~full | pop);

    assign rd_data = rd_valid ? mem[rd_ptr] : 8'h00;

    // The storage array is not reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A set on the same edge as a clear takes priority.
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_output_fifo.sv
// Scoreboard bench for cpu_output_fifo.
// A count-and-queue reference model feeds expected bytes to a negedge monitor.
module tb_cpu_output_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_ready;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          stall;
    logic          overflow;
    logic          ovf_clr;

    int            n_vec  = 0;
    int            n_fail = 0;
    logic [7:0]    sb_q[$];
    int            m_level = 0;
    bit            m_ovf   = 0;
    bit            m_pop;
    bit            m_push;

    cpu_output_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .stall    (stall),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an occupancy count plus the queue of accepted bytes, advanced at each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_pop  = (m_level != 0) && rd_ready;
            m_push = wr_en && ((m_level < DEPTH) || m_pop);
            if (wr_en && (m_level == DEPTH) && !m_pop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (m_push) sb_q.push_back(wr_data);
            m_level = m_level + int'(m_push) - int'(m_pop);
        end
    end

    always @(negedge rst) begin
        m_level = 0;
        m_ovf   = 1'b0;
        sb_q.delete();
    end

    // Monitor: compares flags against the model and consumes bytes as the DUT hands them over.
    always @(negedge clk) begin
        check("level", int'(level), m_level);
        check("full", int'(full), int'(m_level == DEPTH));
        check("empty", int'(empty), int'(m_level == 0));
        check("stall", int'(stall), int'(m_level == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));
        check("rd_valid", int'(rd_valid), int'(m_level != 0));
        if (!rd_valid) begin
            check("rd_data_idle", int'(rd_data), 0);
        end else if (sb_q.size() == 0) begin
            check("sb_depth", sb_q.size(), 1);
        end else begin
            check("rd_data", int'(rd_data), int'(sb_q[0]));
            if (rd_ready) void'(sb_q.pop_front());
        end
    end

    task automatic apply_stimulus(input logic we, input logic [7:0] d, input logic rr, input logic clr);
        wr_en    = we;
        wr_data  = d;
        rd_ready = rr;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output_reset();
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_level", int'(level), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_overflow", int'(overflow), 0);
    endtask

    initial begin
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        #2;
        check_output_reset();
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // Three writes held, then drained in order.
        apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill, overflow with a dropped byte, then clear the sticky flag.
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Write while full is accepted because a pop happens on the same edge.
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming through twice around the pointer range.
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 8'(i), 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset without a clock edge while five bytes are queued.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_output_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 8'h7E, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_data", int'(rd_data), 8'h7E);
        check("post_rst_level", int'(level), 1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic: first biased toward filling, then toward draining.
        for (int i = 0; i < 300; i++)
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom()),
                           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < 300; i++)
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom()),
                           1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < DEPTH + 2; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
